// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSRs with trap entry, mret restore and a 64-bit cycle counter
module csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1,
  parameter bit          COUNTER_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic        is_mret,
  input  logic [2:0]  irq,
  output logic        trap_taken,
  output logic        redirect,
  output logic [31:0] redirect_pc
);
  logic        mie_b, mpie_b, mc_int, mapped, we, int_pend, exc, mret_go;
  logic [2:0]  mie_r, mip_r, pm;
  logic [3:0]  mc_code, icode;
  logic [31:0] mtvec, mscratch, mepc, old, wval;
  logic [63:0] mcycle;
  // old value of the addressed CSR and whether the address exists
  always_comb begin
    old = '0;
    mapped = 1'b1;
    case (csr_addr)
      12'h300: old = {19'b0, 2'b11, 3'b0, mpie_b, 3'b0, mie_b, 3'b0};
      12'h304: old = {20'b0, mie_r[2], 3'b0, mie_r[1], 3'b0, mie_r[0], 3'b0};
      12'h305: old = mtvec;
      12'h340: old = mscratch;
      12'h341: old = mepc;
      12'h342: old = {mc_int, 27'b0, mc_code};
      12'h344: old = {20'b0, mip_r[2], 3'b0, mip_r[1], 3'b0, mip_r[0], 3'b0};
      12'hB00: begin old = mcycle[31:0]; mapped = COUNTER_EN; end
      12'hB80: begin old = mcycle[63:32]; mapped = COUNTER_EN; end
      default: mapped = 1'b0;
    endcase
  end
  assign csr_illegal = |csr_op & ~mapped;
  assign csr_rdata   = (|csr_op & mapped) ? old : '0;
  assign wval        = csr_op == 2'b01 ? csr_wdata : csr_op == 2'b10 ? old | csr_wdata : old & ~csr_wdata;
  assign pm          = mip_r & mie_r;
  assign icode       = pm[2] ? 4'd11 : pm[0] ? 4'd3 : 4'd7;
  assign int_pend    = mie_b & |pm & instr_valid;
  assign exc         = exc_valid & instr_valid;
  assign trap_taken  = exc | int_pend;
  assign mret_go     = instr_valid & is_mret & ~trap_taken & rst;
  assign we          = instr_valid & |csr_op & mapped & ~trap_taken & ~is_mret;
  assign redirect    = trap_taken | mret_go;
  assign redirect_pc = trap_taken ? {mtvec[31:2], 2'b00} + ((~exc & mtvec[0]) ? {26'b0, icode, 2'b00} : 32'b0)
                     : mret_go ? mepc : '0;
  // state update: trap beats mret beats CSR write; counter runs unless a half is written
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mie_b <= 1'b0;
      mpie_b <= 1'b0;
      mie_r <= '0;
      mip_r <= '0;
      mtvec <= {MTVEC_RESET[31:2], 2'b00};
      mscratch <= '0;
      mepc <= '0;
      mc_int <= 1'b0;
      mc_code <= '0;
      mcycle <= '0;
    end else begin
      mip_r <= irq;
      mcycle <= mcycle + 64'd1;
      if (trap_taken) begin
        mepc <= pc & ~32'h3;
        mc_int <= ~exc;
        mc_code <= exc ? exc_cause : icode;
        mpie_b <= mie_b;
        mie_b <= 1'b0;
      end else if (mret_go) begin
        mie_b <= mpie_b;
        mpie_b <= 1'b1;
      end else if (we)
        case (csr_addr)
          12'h300: begin mie_b <= wval[3]; mpie_b <= wval[7]; end
          12'h304: mie_r <= {wval[11], wval[7], wval[3]};
          12'h305: mtvec <= {wval[31:2], 1'b0, wval[1:0] == 2'b00 ? 1'b0
                            : (wval[1:0] == 2'b01 && VECTORED_EN) ? 1'b1 : mtvec[0]};
          12'h340: mscratch <= wval;
          12'h341: mepc <= wval & ~32'h3;
          12'h342: begin mc_int <= wval[31]; mc_code <= wval[3:0]; end
          12'hB00: mcycle <= {mcycle[63:32], wval};
          12'hB80: mcycle <= {wval, mcycle[31:0]};
          default: ;
        endcase
    end
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed checks of CSR access, trap sequencing and the cycle counter
module tb_csr_unit;
  logic        clk = 1'b0, rst = 1'b0;
  logic [1:0]  csr_op = '0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0, csr_rdata, pc = '0, redirect_pc, o;
  logic        csr_illegal, instr_valid = 1'b0, exc_valid = 1'b0, is_mret = 1'b0;
  logic        trap_taken, redirect;
  logic [3:0]  exc_cause = '0;
  logic [2:0]  irq = '0;
  int total = 0, bad = 0;
  csr_unit dut (
    .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .instr_valid(instr_valid), .pc(pc),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .is_mret(is_mret), .irq(irq),
    .trap_taken(trap_taken), .redirect(redirect), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic rchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    instr_valid = 1'b0;
    csr_op = 2'b10;
    csr_addr = a;
    csr_wdata = '0;
    #1;
    chk(tag, csr_rdata, exp);
    csr_op = 2'b00;
  endtask
  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d, output logic [31:0] oldv);
    instr_valid = 1'b1;
    csr_op = op;
    csr_addr = a;
    csr_wdata = d;
    #1;
    oldv = csr_rdata;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    csr_op = 2'b00;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  initial begin
    #2;
    instr_valid = 1'b1;
    exc_valid = 1'b1;
    exc_cause = 4'd2;
    #1;
    chk("rst_exc_trap", {31'b0, trap_taken}, 32'd1);
    chk("rst_exc_target", redirect_pc, 32'h0);
    exc_valid = 1'b0;
    is_mret = 1'b1;
    #1;
    chk("rst_mret_redirect", {31'b0, redirect}, 32'd0);
    is_mret = 1'b0;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rchk("rst_mstatus", 12'h300, 32'h1800);
    rchk("rst_mtvec", 12'h305, 32'h0);
    rchk("rst_mip", 12'h344, 32'h0);
    rchk("rst_mepc", 12'h341, 32'h0);
    wr(2'b01, 12'h300, 32'h8, o);
    chk("wr_old", o, 32'h1800);
    wr(2'b10, 12'h300, 32'h80, o);
    chk("set_old", o, 32'h1808);
    rchk("set_val", 12'h300, 32'h1888);
    wr(2'b11, 12'h300, 32'h8, o);
    chk("clr_old", o, 32'h1888);
    rchk("clr_val", 12'h300, 32'h1880);
    wr(2'b01, 12'h305, 32'h101, o);
    rchk("mtvec_vec", 12'h305, 32'h101);
    wr(2'b01, 12'h304, 32'h80, o);
    rchk("mie_val", 12'h304, 32'h80);
    wr(2'b10, 12'h300, 32'h8, o);
    irq = 3'b010;
    pc = 32'h40;
    instr_valid = 1'b1;
    #1;
    chk("irq_no_trap_yet", {31'b0, trap_taken}, 32'd0);
    @(posedge clk);
    #1;
    chk("irq_trap", {31'b0, trap_taken}, 32'd1);
    chk("irq_vec_target", redirect_pc, 32'h11C);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    irq = 3'b000;
    @(posedge clk);
    #1;
    rchk("irq_mepc", 12'h341, 32'h40);
    rchk("irq_mcause", 12'h342, 32'h8000_0007);
    rchk("irq_mstatus", 12'h300, 32'h1880);
    instr_valid = 1'b1;
    is_mret = 1'b1;
    #1;
    chk("mret_redirect", {31'b0, redirect}, 32'd1);
    chk("mret_target", redirect_pc, 32'h40);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    is_mret = 1'b0;
    rchk("mret_mstatus", 12'h300, 32'h1888);
    irq = 3'b010;
    @(posedge clk);
    #1;
    instr_valid = 1'b1;
    exc_valid = 1'b1;
    exc_cause = 4'd2;
    pc = 32'h80;
    csr_op = 2'b01;
    csr_addr = 12'h340;
    csr_wdata = 32'hDEAD_BEEF;
    #1;
    chk("prio_trap", {31'b0, trap_taken}, 32'd1);
    chk("prio_target", redirect_pc, 32'h100);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    exc_valid = 1'b0;
    csr_op = 2'b00;
    irq = 3'b000;
    rchk("prio_mcause", 12'h342, 32'h2);
    rchk("prio_mepc", 12'h341, 32'h80);
    rchk("prio_dropped", 12'h340, 32'h0);
    rchk("prio_mstatus", 12'h300, 32'h1880);
    @(posedge clk);
    #1;
    wr(2'b01, 12'h341, 32'h123, o);
    rchk("mepc_align", 12'h341, 32'h120);
    wr(2'b01, 12'h305, 32'h202, o);
    rchk("mtvec_mode_keep", 12'h305, 32'h201);
    instr_valid = 1'b1;
    csr_op = 2'b01;
    csr_addr = 12'h344;
    csr_wdata = 32'hFFF;
    #1;
    chk("mip_legal", {31'b0, csr_illegal}, 32'd0);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    csr_op = 2'b00;
    rchk("mip_ro", 12'h344, 32'h0);
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF, o);
    wr(2'b01, 12'hB80, 32'hFFFF_FFFF, o);
    rchk("cyc_lo_max", 12'hB00, 32'hFFFF_FFFF);
    rchk("cyc_hi_max", 12'hB80, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    rchk("cyc_hi_wrap", 12'hB80, 32'h0);
    rchk("cyc_lo_wrap", 12'hB00, 32'h0);
    instr_valid = 1'b1;
    csr_op = 2'b01;
    csr_addr = 12'h7C0;
    csr_wdata = 32'hFFFF_FFFF;
    #1;
    chk("ill_flag", {31'b0, csr_illegal}, 32'd1);
    chk("ill_rdata", csr_rdata, 32'h0);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    csr_op = 2'b00;
    #1;
    chk("ill_no_op", {31'b0, csr_illegal}, 32'd0);
    rchk("ill_mstatus", 12'h300, 32'h1880);
    rchk("ill_mscratch", 12'h340, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode CSR unit for the 3-stage pipeline, replacing the fixed four-entry CSR array. It provides full RISC-V machine-mode trap sequencing: interrupt masking and priority, synchronous exceptions, direct or vectored `mtvec`, and `mret` restore. It also supports atomic write, set and clear CSR operations and a 64-bit cycle counter. It sits beside the execute stage and drives the PC redirect mux.

## Interface
- `MTVEC_RESET`, default 32'h0000_0000: reset value of `mtvec`. Bits [1:0] are forced to 0.
- `VECTORED_EN`, default 1: when 1, `mtvec.MODE` = 1 (vectored) is legal. When 0, MODE is hardwired to 0.
- `COUNTER_EN`, default 1: when 1, `mcycle`/`mcycleh` exist. When 0, their addresses are unmapped.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `csr_op`  in  2  00 none, 01 write (csrrw), 10 set (csrrs), 11 clear (csrrc).
- `csr_addr`  in  12  CSR address.
- `csr_wdata`  in  32  operand (rs1 or zimm).
- `csr_rdata`  out  32  old value of the addressed CSR; combinational.
- `csr_illegal`  out  1  `csr_op`≠0 and address unmapped; combinational.
- `instr_valid`  in  1  a real instruction occupies the stage this cycle.
- `pc`  in  32  PC of that instruction.
- `exc_valid`  in  1  synchronous exception raised by that instruction.
- `exc_cause`  in  4  exception code.
- `is_mret`  in  1  instruction is `mret`.
- `irq`  in  3  {external, timer, software} level interrupt requests.
- `trap_taken`  out  1  trap entry this cycle; combinational.
- `redirect`  out  1  PC must be replaced this cycle (trap or `mret`).
- `redirect_pc`  out  32  target PC, valid when `redirect`=1.

## Operation
- CSR map:
  - `mstatus` 0x300: MIE bit 3, MPIE bit 7, MPP[12:11] hardwired to 2'b11; other bits read as 0.
  - `mie` 0x304: MSIE bit 3, MTIE bit 7, MEIE bit 11 are writable; other bits read as 0.
  - `mtvec` 0x305: BASE [31:2], MODE [1:0]. A write with MODE∉{0, VECTORED_EN?1:0} leaves MODE unchanged.
  - `mscratch` 0x340: full 32 bits.
  - `mepc` 0x341: bits [1:0] always 0.
  - `mcause` 0x342: bit 31 is the interrupt flag, [3:0] is the code; other bits 0.
  - `mip` 0x344: MSIP 3, MTIP 7, MEIP 11. Read-only; writes are silently ignored (not illegal).
  - `mcycle` 0xB00, `mcycleh` 0xB80.
- Write value:
  - write: `wdata`.
  - set: `old | wdata`.
  - clear: `old & ~wdata`.
  - The result is then masked by the field rules above.
- `csr_rdata` = old value of the addressed CSR when `csr_op`≠0; otherwise 0. It is 0 on an illegal address.
- A CSR write commits only when `instr_valid`=1, `csr_illegal`=0 and `trap_taken`=0.
- `mip` register: `mip[3]`, `[7]`, `[11]` are set from `irq` each cycle (1-cycle registered sample).
- Interrupt pending: `int_pend` = `mstatus.MIE` & |(`mip` & `mie`) & `instr_valid`.
- Interrupt priority: MEI (11) > MSI (3) > MTI (7).
- Event priority in one cycle: `exc_valid` > `int_pend` > `is_mret` > CSR write. Only the winner has effect.
- Trap entry (`trap_taken`=1, `redirect`=1), committed at the next edge:
  - `mepc` ← `pc`.
  - `mcause` ← {1, code} for an interrupt, {0, `exc_cause`} for an exception.
  - MPIE ← MIE; MIE ← 0.
- Trap target:
  - `{BASE,2'b00}` for exceptions, and for all traps when MODE = 0.
  - `{BASE,2'b00}` + 4×code for interrupts when MODE = 1.
- `mret` (`instr_valid`=1, no trap): `redirect`=1, `redirect_pc` = `mepc`; MIE ← MPIE, MPIE ← 1.
- `mcycle`:
  - 64-bit counter, incremented every cycle; wraps from 2^64−1 to 0.
  - A CSR write to either half replaces that half, with no increment that cycle; the other half holds.

## Timing
- Reset (`rst`=0, async) values:
  - `mstatus` reads 0x0000_1800.
  - `mie`, `mip`, `mscratch`, `mepc`, `mcause`, `mcycle` = 0.
  - `mtvec` = `MTVEC_RESET` with MODE = 0.
- Outputs during reset: `redirect`/`trap_taken` = 0 unless `exc_valid`=1 and `instr_valid`=1.
- `irq` → `mip` visible: 1 cycle. `irq` → `trap_taken`: 1 cycle, provided MIE and the `mie` bit are set.
- All outputs are combinational from the current state and inputs. State commits at the rising edge after the event.
- Release of reset mid-operation: the counter starts at 0 on the first edge after deassertion.

## Test plan
- Reset: after reset, read 0x300 → 0x1800, 0x305 → `MTVEC_RESET`, 0x344 → 0.
- Set/clear: write 0x300 ← 0x8, then set 0x300 with 0x80 → reads 0x1888. Clear 0x300 with 0x8 → reads 0x1880. Read on the write cycle returns the old value.
- Vectored interrupt: `mtvec`=0x101, `mie`=0x80, MIE=1, `irq`=3'b010, `pc`=0x40.
  - One cycle later `redirect_pc`=0x11C.
  - Then `mepc`=0x40, `mcause`=0x8000_0007, `mstatus`=0x1880.
- Priority: `exc_valid`=1 (cause 2) with a timer interrupt pending and a CSR write on the same cycle → `mcause`=2, target = BASE, CSR write dropped.
- `mret`: after the trap above, `is_mret`=1 → `redirect_pc`=0x40, then `mstatus`=0x1888.
- Counter/illegal:
  - Write `mcycle`=0xFFFF_FFFF, `mcycleh`=0xFFFF_FFFF → wraps to 0 two edges later.
  - Access 0x7C0 → `csr_illegal`=1, `rdata`=0, no state change.
